// File: rtl/pla_prog_ctrl_pkg.sv
// Shared types and constants for the programmable PLA controller.
package pla_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int unsigned ROWS  = 16;
    localparam int unsigned N_OUT = 4;

    // Row r occupies bits [4r+3:4r]; reproduces the fixed F1..F4 decode on A,B.
    localparam logic [ROWS*N_OUT-1:0] DEFAULT_MASK = 64'h8888_4444_2222_1111;

endpackage

// File: rtl/pla_prog_ctrl_if.sv
// Evaluation and configuration handshakes of the programmable PLA.
interface pla_prog_ctrl_if;
    import pla_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_abcd;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_f;
    logic             cfg_start;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [N_OUT-1:0] cfg_data;
    logic             cfg_done;

    modport master (
        output in_valid, in_abcd, out_ready, cfg_start, cfg_valid, cfg_data,
        input  in_ready, out_valid, out_f, cfg_ready, cfg_done
    );

    modport slave (
        input  in_valid, in_abcd, out_ready, cfg_start, cfg_valid, cfg_data,
        output in_ready, out_valid, out_f, cfg_ready, cfg_done
    );

endinterface

// File: rtl/pla_prog_ctrl_plane.sv
// Combinational OR-plane lookup: one mask row per one-hot minterm.
module pla_plane
    import pla_pkg::*;
(
    input  logic [ROWS*N_OUT-1:0] mask,
    input  logic [3:0]            idx,
    output logic [N_OUT-1:0]      f
);

    // Select the row addressed by the minterm index.
    always_comb begin
        f = mask[{idx, 2'b00} +: N_OUT];
    end

endmodule

// File: rtl/pla_prog_ctrl.sv
// Sequencing controller: registered PLA evaluation plus nibble-serial mask reload.
module pla_prog_ctrl
    import pla_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    pla_prog_ctrl_if.slave  bus
);

    state_t                 state, next_state;
    logic [3:0]             row_cnt;
    logic [ROWS*N_OUT-1:0]  active_mask;
    logic [ROWS*N_OUT-1:0]  shadow_mask;
    logic [ROWS*N_OUT-1:0]  shadow_next;
    logic [N_OUT-1:0]       plane_f;
    logic                   in_acc;
    logic                   cfg_acc;
    logic                   abort;
    logic                   commit;

    pla_plane u_plane (
        .mask (active_mask),
        .idx  (bus.in_abcd),
        .f    (plane_f)
    );

    assign bus.in_ready  = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign bus.cfg_ready = (state == LOAD);
    assign in_acc        = bus.in_valid && bus.in_ready;
    assign cfg_acc       = bus.cfg_valid && bus.cfg_ready;
    assign abort         = (state == LOAD) && bus.cfg_start;
    assign commit        = cfg_acc && !bus.cfg_start && (row_cnt == 4'd15);

    // Next-state decode; an input accepted alongside cfg_start must drain first.
    always_comb begin
        next_state = state;
        unique case (state)
            RUN: begin
                if (bus.cfg_start) begin
                    if (!in_acc && (!bus.out_valid || bus.out_ready)) next_state = LOAD;
                    else                                              next_state = DRAIN;
                end
            end
            DRAIN:   if (!bus.out_valid) next_state = LOAD;
            LOAD:    if (commit)         next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    // Shadow image with the currently offered row merged in.
    always_comb begin
        shadow_next = shadow_mask;
        if (cfg_acc) shadow_next[{row_cnt, 2'b00} +: N_OUT] = bus.cfg_data;
    end

    // Row counter, shadow and active mask; the last row is committed from shadow_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt     <= '0;
            shadow_mask <= DEFAULT_MASK;
            active_mask <= DEFAULT_MASK;
            bus.cfg_done <= 1'b0;
        end else begin
            bus.cfg_done <= commit;
            if (state != LOAD || abort) begin
                row_cnt <= '0;
                if (abort) shadow_mask <= active_mask;
            end else if (cfg_acc) begin
                row_cnt     <= row_cnt + 4'd1;
                shadow_mask <= shadow_next;
                if (commit) active_mask <= shadow_next;
            end
        end
    end

    // Output register: load on acceptance, hold while stalled, clear when taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_f     <= '0;
        end else if (in_acc) begin
            bus.out_valid <= 1'b1;
            bus.out_f     <= plane_f;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pla_prog_ctrl.sv
// Directed self-checking bench for pla_prog_ctrl.
module tb_pla_prog_ctrl;
    import pla_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pla_prog_ctrl_if ifc ();

    pla_prog_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Default decode written from the F1..F4 on A,B description.
    function automatic logic [3:0] dflt_f(input logic [3:0] abcd);
        logic [1:0] ab;
        ab = abcd[3:2];
        return 4'b0001 << ab;
    endfunction

    localparam logic [63:0] IDENT_MASK = 64'hFEDC_BA98_7654_3210;

    logic [3:0] vec [8];
    logic [3:0] hold_f;
    logic       m_valid;
    logic       stalled;
    int         i;
    int         j;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        ifc.in_valid = 0; ifc.in_abcd = '0; ifc.out_ready = 0;
        ifc.cfg_start = 0; ifc.cfg_valid = 0; ifc.cfg_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_out_f",     64'(ifc.out_f), 64'd0);
        chk("rst_cfg_done",  64'(ifc.cfg_done), 64'd0);
        chk("rst_cfg_ready", 64'(ifc.cfg_ready), 64'd0);
        chk("rst_in_ready",  64'(ifc.in_ready), 64'd1);
        chk("rst_state",     64'(dut.state), 64'(RUN));
        chk("rst_mask",      dut.active_mask, 64'h8888_4444_2222_1111);

        // Stream through the default mask, latency 1
        rst = 1'b0;
        ifc.out_ready = 1; ifc.in_valid = 1;
        ifc.in_abcd = 4'd0;  tick(); chk("dflt_0",  64'(ifc.out_f), 64'h1); chk("dflt_v0", 64'(ifc.out_valid), 64'd1);
        ifc.in_abcd = 4'd5;  tick(); chk("dflt_5",  64'(ifc.out_f), 64'h2);
        ifc.in_abcd = 4'd9;  tick(); chk("dflt_9",  64'(ifc.out_f), 64'h4);
        ifc.in_abcd = 4'd15; tick(); chk("dflt_15", 64'(ifc.out_f), 64'h8);
        ifc.in_valid = 0;    tick(); chk("dflt_empty", 64'(ifc.out_valid), 64'd0);

        // Identity reload
        ifc.cfg_start = 1; tick(); ifc.cfg_start = 0;
        chk("ld_state", 64'(dut.state), 64'(LOAD));
        chk("ld_cfg_ready", 64'(ifc.cfg_ready), 64'd1);
        chk("ld_in_ready", 64'(ifc.in_ready), 64'd0);
        for (int r = 0; r < 16; r++) begin
            ifc.cfg_valid = 1; ifc.cfg_data = 4'(r);
            if (r == 15) chk("ld_done_early", 64'(ifc.cfg_done), 64'd0);
            tick();
        end
        ifc.cfg_valid = 0;
        chk("ld_done",      64'(ifc.cfg_done), 64'd1);
        chk("ld_run",       64'(dut.state), 64'(RUN));
        chk("ld_in_ready1", 64'(ifc.in_ready), 64'd1);
        chk("ld_mask",      dut.active_mask, IDENT_MASK);
        ifc.in_valid = 1; ifc.in_abcd = 4'hA; tick();
        chk("ld_done_pulse", 64'(ifc.cfg_done), 64'd0);
        chk("id_A", 64'(ifc.out_f), 64'hA);
        ifc.in_abcd = 4'h3; tick(); chk("id_3", 64'(ifc.out_f), 64'h3);
        ifc.in_valid = 0; tick();

        // Pending result then cfg_start -> DRAIN
        ifc.out_ready = 0; ifc.in_valid = 1; ifc.in_abcd = 4'h6; tick();
        ifc.in_valid = 0;
        chk("dr_pend", 64'(ifc.out_f), 64'h6);
        ifc.cfg_start = 1; tick(); ifc.cfg_start = 0;
        chk("dr_state", 64'(dut.state), 64'(DRAIN));
        chk("dr_cfg_ready", 64'(ifc.cfg_ready), 64'd0);
        chk("dr_in_ready", 64'(ifc.in_ready), 64'd0);
        tick();
        chk("dr_hold_f", 64'(ifc.out_f), 64'h6);
        chk("dr_hold_v", 64'(ifc.out_valid), 64'd1);
        ifc.out_ready = 1; tick();
        chk("dr_taken", 64'(ifc.out_valid), 64'd0);
        tick();
        chk("dr_to_load", 64'(dut.state), 64'(LOAD));

        // Abort after 7 rows, then 16 rows of F
        for (int r = 0; r < 7; r++) begin
            ifc.cfg_valid = 1; ifc.cfg_data = 4'h0; tick();
        end
        chk("ab_cnt7", 64'(dut.row_cnt), 64'd7);
        ifc.cfg_valid = 0; ifc.cfg_start = 1; tick(); ifc.cfg_start = 0;
        chk("ab_cnt0", 64'(dut.row_cnt), 64'd0);
        chk("ab_state", 64'(dut.state), 64'(LOAD));
        for (int r = 0; r < 16; r++) begin
            if (r == 15) begin
                chk("ab_mask_kept", dut.active_mask, IDENT_MASK);
                chk("ab_no_done", 64'(ifc.cfg_done), 64'd0);
            end
            ifc.cfg_valid = 1; ifc.cfg_data = 4'hF; tick();
        end
        ifc.cfg_valid = 0;
        chk("ab_done", 64'(ifc.cfg_done), 64'd1);
        ifc.in_valid = 1;
        ifc.in_abcd = 4'h0; tick(); chk("f_0", 64'(ifc.out_f), 64'hF);
        ifc.in_abcd = 4'h7; tick(); chk("f_7", 64'(ifc.out_f), 64'hF);
        ifc.in_abcd = 4'hC; tick(); chk("f_C", 64'(ifc.out_f), 64'hF);
        ifc.in_valid = 0; tick();

        // Reset during LOAD after 10 rows
        ifc.cfg_start = 1; tick(); ifc.cfg_start = 0;
        for (int r = 0; r < 10; r++) begin
            ifc.cfg_valid = 1; ifc.cfg_data = 4'h5; tick();
        end
        ifc.cfg_valid = 0;
        rst = 1'b1; #1;
        chk("rl_state", 64'(dut.state), 64'(RUN));
        chk("rl_mask", dut.active_mask, 64'h8888_4444_2222_1111);
        chk("rl_cfg_ready", 64'(ifc.cfg_ready), 64'd0);
        tick();
        rst = 1'b0;
        ifc.in_valid = 1; ifc.in_abcd = 4'hC; tick();
        chk("rl_C", 64'(ifc.out_f), 64'h8);
        ifc.in_valid = 0; tick();

        // Backpressure with out_ready toggling
        vec[0] = 4'h1; vec[1] = 4'h4; vec[2] = 4'h8; vec[3] = 4'hD;
        vec[4] = 4'h2; vec[5] = 4'hF; vec[6] = 4'h6; vec[7] = 4'hB;
        i = 0; j = 0; m_valid = 0; stalled = 0;
        for (int cyc = 0; cyc < 60 && j < 8; cyc++) begin
            ifc.out_ready = (cyc % 2 == 0);
            if (i < 8) begin ifc.in_valid = 1; ifc.in_abcd = vec[i]; end
            else       ifc.in_valid = 0;
            #1;
            if (stalled) chk("bp_stable", 64'(ifc.out_f), 64'(hold_f));
            chk("bp_out_valid", 64'(ifc.out_valid), 64'(m_valid));
            chk("bp_in_ready", 64'(ifc.in_ready), 64'(!m_valid || ifc.out_ready));
            stalled = 0;
            if (m_valid && ifc.out_ready) begin
                chk("bp_data", 64'(ifc.out_f), 64'(dflt_f(vec[j])));
                j++;
            end else if (m_valid) begin
                stalled = 1; hold_f = dflt_f(vec[j]);
            end
            if (i < 8 && (!m_valid || ifc.out_ready)) begin
                m_valid = 1; i++;
            end else if (ifc.out_ready) begin
                m_valid = 0;
            end
            tick();
        end
        chk("bp_delivered", 64'(j), 64'd8);
        ifc.in_valid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
